fp32_to_fixed: RTL and testbench

- Converts IEEE754 single-precision quotients from the subpixel-edge divider path back to signed two's-complement fixed point.
- Output feeds the downstream coordinate accumulation logic.
- Sits directly after the divider pair. Accepts one float per cycle with its divbyzero flag.
- 3-stage pipeline with valid/ready backpressure, round-to-nearest and saturation.

---
 rtl/fixed_pkg.sv | 24 ++
 rtl/fp32_unpack.sv | 35 +++
 rtl/fp32_to_fixed.sv | 132 +++++++++++++
 tb/tb_fp32_to_fixed.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared constants and types for the float-to-fixed converter.
// The unpacked bundle is the stage-1 register payload.
package fixed_pkg;

   localparam int FP_EXP_BIAS = 127;
   localparam int FP_EXP_MAX  = 255;
   localparam int FP_MANT_W   = 23;
   localparam int SH_W        = 10;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_SAT  = 2'd2,
      CLS_ERR  = 2'd3
   } fp_class_t;

   typedef struct packed {
      logic                   sign;
      fp_class_t              cls;
      logic [FP_MANT_W:0]     sig;
      logic signed [SH_W-1:0] sh;
   } unpack_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits an fp32 word into sign/significand, classifies it and
// computes the alignment shift toward the fixed-point grid.
module fp32_unpack
   import fixed_pkg::*;
#(
   parameter int FRAC_W = 8
) (
   input  logic [31:0] data,
   input  logic        divbyzero,
   output unpack_t     u
);

   logic [7:0]           e;
   logic [FP_MANT_W-1:0] m;

   assign e = data[30:23];
   assign m = data[FP_MANT_W-1:0];

   always_comb begin
      u.sign = data[31];
      u.sig  = {1'b1, m};
      u.sh   = SH_W'(e) - SH_W'(FP_EXP_BIAS + FP_MANT_W)
             + SH_W'(FRAC_W);
      // divider fault outranks anything encoded in the word
      if (divbyzero)
         u.cls = CLS_ERR;
      else if (e == 8'(FP_EXP_MAX))
         u.cls = (m != '0) ? CLS_ERR : CLS_SAT;
      else if (e == '0)
         u.cls = CLS_ZERO;
      else
         u.cls = CLS_NORM;
   end

endmodule

// File: rtl/fp32_to_fixed.sv
// Three-stage fp32 to signed fixed-point converter with
// round-half-away-from-zero, saturation and a shared stall.
module fp32_to_fixed
   import fixed_pkg::*;
#(
   parameter  int INT_W  = 12,
   parameter  int FRAC_W = 8,
   localparam int OUT_W  = INT_W + FRAC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_divbyzero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic             out_err
);

   localparam int SIG_W = FP_MANT_W + 1;
   localparam int MW    = SIG_W + OUT_W;
   localparam int HW    = MW - OUT_W + 1;
   localparam int RW    = SIG_W + 1;

   localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic adv;

   unpack_t u;
   unpack_t s1;
   logic    s1_valid;

   logic             s2_valid;
   logic             s2_sign;
   fp_class_t        s2_cls;
   logic             s2_ovf;
   logic [OUT_W-1:0] s2_mag;

   logic [SH_W-1:0]  nsh;
   logic [SIG_W-1:0] t;
   logic [RW-1:0]    rnd;
   logic [MW-1:0]    mag_w;
   logic [HW-1:0]    hi;
   logic             big;
   logic             min_ok;
   logic             ovf;

   logic [OUT_W-1:0] res;
   logic             sat;
   logic             err;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   fp32_unpack #(.FRAC_W(FRAC_W)) u_unpack (
      .data      (in_data),
      .divbyzero (in_divbyzero),
      .u         (u)
   );

   always_comb begin
      nsh   = SH_W'(-s1.sh);
      t     = '0;
      rnd   = '0;
      mag_w = '0;
      big   = 1'b0;
      if (!s1.sh[SH_W-1]) begin
         if ($unsigned(s1.sh) > SH_W'(OUT_W - 1))
            big = 1'b1;
         else
            mag_w = MW'(s1.sig) << s1.sh;
      end else if (nsh <= SH_W'(SIG_W)) begin
         // keep one extra bit so adding 1 then halving rounds
         t     = s1.sig >> (nsh - SH_W'(1));
         rnd   = {1'b0, t} + RW'(1);
         mag_w = MW'(rnd[RW-1:1]);
      end
      hi     = mag_w[MW-1:OUT_W-1];
      min_ok = s1.sign && (hi == HW'(1))
             && (mag_w[OUT_W-2:0] == '0);
      ovf    = big || ((hi != '0) && !min_ok);
   end

   always_comb begin
      res = '0;
      sat = 1'b0;
      err = 1'b0;
      unique case (1'b1)
         s2_cls == CLS_ERR: err = 1'b1;
         (s2_cls == CLS_SAT) || (s2_cls == CLS_NORM && s2_ovf): begin
            sat = 1'b1;
            res = s2_sign ? SAT_MIN : SAT_MAX;
         end
         s2_cls == CLS_NORM && !s2_ovf:
            res = s2_sign ? OUT_W'(-s2_mag) : s2_mag;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1        <= '0;
         s2_valid  <= 1'b0;
         s2_sign   <= 1'b0;
         s2_cls    <= CLS_ZERO;
         s2_ovf    <= 1'b0;
         s2_mag    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_err   <= 1'b0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s1        <= u;
         s2_valid  <= s1_valid;
         s2_sign   <= s1.sign;
         s2_cls    <= s1.cls;
         s2_ovf    <= ovf;
         s2_mag    <= mag_w[OUT_W-1:0];
         out_valid <= s2_valid;
         out_data  <= res;
         out_sat   <= sat;
         out_err   <= err;
      end
   end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Scoreboard bench for fp32_to_fixed: directed vectors,
// output stall and mid-stream reset.
module tb_fp32_to_fixed;

   localparam int OUT_W = 20;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_data = '0;
   logic             in_divbyzero = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OUT_W-1:0] out_data;
   logic             out_sat;
   logic             out_err;

   typedef struct {
      logic [31:0] data;
      logic        sat;
      logic        err;
      int          acc;
      bit          lat;
   } exp_t;

   typedef struct packed {
      logic [31:0] f;
      logic        z;
      logic [31:0] q;
      logic        s;
      logic        e;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   vec_t vecs[19] = '{
      '{32'h3FC00000, 1'b0, 32'h00180, 1'b0, 1'b0},
      '{32'hC0100000, 1'b0, 32'hFFDC0, 1'b0, 1'b0},
      '{32'h3F800000, 1'b0, 32'h00100, 1'b0, 1'b0},
      '{32'h3B000000, 1'b0, 32'h00001, 1'b0, 1'b0},
      '{32'hBB000000, 1'b0, 32'hFFFFF, 1'b0, 1'b0},
      '{32'h3A800000, 1'b0, 32'h00000, 1'b0, 1'b0},
      '{32'hBA800000, 1'b0, 32'h00000, 1'b0, 1'b0},
      '{32'h3F804000, 1'b0, 32'h00101, 1'b0, 1'b0},
      '{32'hBF804000, 1'b0, 32'hFFEFF, 1'b0, 1'b0},
      '{32'h453B8000, 1'b0, 32'h7FFFF, 1'b1, 1'b0},
      '{32'hC5000000, 1'b0, 32'h80000, 1'b0, 1'b0},
      '{32'h7F800000, 1'b0, 32'h7FFFF, 1'b1, 1'b0},
      '{32'hFF800000, 1'b0, 32'h80000, 1'b1, 1'b0},
      '{32'h44FFFFFF, 1'b0, 32'h7FFFF, 1'b1, 1'b0},
      '{32'h3F800000, 1'b1, 32'h00000, 1'b0, 1'b1},
      '{32'h7FC00000, 1'b0, 32'h00000, 1'b0, 1'b1},
      '{32'h7FC00000, 1'b1, 32'h00000, 1'b0, 1'b1},
      '{32'h00000001, 1'b0, 32'h00000, 1'b0, 1'b0},
      '{32'h80000000, 1'b0, 32'h00000, 1'b0, 1'b0}
   };

   vec_t bp[6] = '{
      '{32'h3F800000, 1'b0, 32'h00100, 1'b0, 1'b0},
      '{32'h40000000, 1'b0, 32'h00200, 1'b0, 1'b0},
      '{32'h40400000, 1'b0, 32'h00300, 1'b0, 1'b0},
      '{32'hBF800000, 1'b0, 32'hFFF00, 1'b0, 1'b0},
      '{32'h3F000000, 1'b0, 32'h00080, 1'b0, 1'b0},
      '{32'h40800000, 1'b0, 32'h00400, 1'b0, 1'b0}
   };

   fp32_to_fixed #(.INT_W(12), .FRAC_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_divbyzero (in_divbyzero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sat      (out_sat),
      .out_err      (out_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got 0x%0h, expected none",
                     out_data);
         end else if (!out_ready) begin
            check("stall_data", 32'(out_data), sb[0].data);
            check("stall_in_ready", 32'(in_ready), 32'd0);
         end else begin
            e = sb.pop_front();
            check("data", 32'(out_data), e.data);
            check("sat", 32'(out_sat), 32'(e.sat));
            check("err", 32'(out_err), 32'(e.err));
            if (e.lat) check("latency", 32'(cyc - e.acc), 32'd3);
         end
      end
   end

   task automatic send(input vec_t v, input bit lat);
      int n = 0;
      in_valid     = 1'b1;
      in_data      = v.f;
      in_divbyzero = v.z;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0, expected 1");
      end else begin
         sb.push_back('{data: v.q, sat: v.s, err: v.e,
                        acc: cyc, lat: lat});
      end
      @(negedge clk);
      in_valid     = 1'b0;
      in_divbyzero = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sat", 32'(out_sat), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) send(vecs[i], 1'b1);
      drain();

      fork
         begin
            foreach (bp[i]) send(bp[i], 1'b0);
         end
         begin : stall
            int n = 0;
            bit seen = 1'b0;
            while (!seen && n < 50) begin
               @(posedge clk);
               #1;
               seen = out_valid;
               n++;
            end
            check("bp_first_valid", 32'(seen), 32'd1);
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) send(bp[i], 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("post_rst_idle", 32'(out_valid), 32'd0);
      end

      send(bp[3], 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
